// File: rtl/aes_arb_pkg.sv
// Shared types and constants for the two-requester aes_core arbiter.
package aes_arb_pkg;

  localparam int unsigned ARB_NUM_REQ = 2;
  localparam int unsigned KEY_W       = 256;
  localparam int unsigned BLK_W       = 128;

  typedef enum logic [2:0] {
    IDLE,
    INIT_ISSUE,
    INIT_WAIT,
    NEXT_ISSUE,
    NEXT_WAIT,
    RESP
  } arb_state_t;

endpackage

// File: rtl/aes_rr_arbiter.sv
// Two-way round-robin grant; last_grant is held by the parent.
module aes_rr_arbiter (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] grant,
  output logic       grant_idx
);

  always_comb begin
    grant     = '0;
    grant_idx = 1'b0;
    if (enable && (|req)) begin
      if (req[0] && req[1]) grant_idx = ~last_grant;
      else                  grant_idx = req[1];
      grant = grant_idx ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/aes_core_arbiter.sv
// Shares one aes_core between two requesters, re-expanding the key only
// when the key context (owner, keylen or explicit rekey) changes.
module aes_core_arbiter
  import aes_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [1:0]         req_encdec,
  input  logic [1:0]         req_keylen,
  input  logic [1:0]         req_rekey,
  input  logic [511:0]       req_key,
  input  logic [255:0]       req_block,
  output logic [1:0]         rsp_valid,
  input  logic [1:0]         rsp_ready,
  output logic [127:0]       rsp_data,
  output logic               core_encdec,
  output logic               core_init,
  output logic               core_next,
  output logic [255:0]       core_key,
  output logic               core_keylen,
  output logic [127:0]       core_block,
  input  logic               core_ready,
  input  logic [127:0]       core_result,
  input  logic               core_result_valid,
  output logic               busy,
  output logic [CNT_W-1:0]   init_cnt,
  output logic [CNT_W-1:0]   op_cnt
);

  if (NUM_REQ != ARB_NUM_REQ) begin : g_num_req_check
    $error("aes_core_arbiter supports only NUM_REQ == 2");
  end

  arb_state_t       state, state_next;
  logic             last_grant;
  logic             key_loaded;
  logic             key_owner;
  logic             seen_busy;
  logic [1:0]       grant;
  logic             grant_idx;
  logic             arb_enable;
  logic [KEY_W-1:0] g_key;
  logic [BLK_W-1:0] g_block;
  logic             g_keylen;
  logic             g_encdec;
  logic             g_rekey;
  logic             need_init;

  assign arb_enable = (state == IDLE);

  aes_rr_arbiter u_rr (
    .req        (req_valid),
    .last_grant (last_grant),
    .enable     (arb_enable),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  assign g_key    = grant_idx ? req_key[2*KEY_W-1:KEY_W]   : req_key[KEY_W-1:0];
  assign g_block  = grant_idx ? req_block[2*BLK_W-1:BLK_W] : req_block[BLK_W-1:0];
  assign g_keylen = req_keylen[grant_idx];
  assign g_encdec = req_encdec[grant_idx];
  assign g_rekey  = req_rekey[grant_idx];

  // core_keylen still holds the previous operation's keylen at grant time
  assign need_init = !key_loaded || (key_owner != grant_idx) || g_rekey ||
                     (g_keylen != core_keylen);

  // last_grant doubles as the index of the in-flight requester
  assign rsp_valid = (state == RESP) ? (last_grant ? 2'b10 : 2'b01) : 2'b00;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = '0;
    core_init  = 1'b0;
    core_next  = 1'b0;
    case (state)
      IDLE: begin
        if (|grant) begin
          req_ready  = grant;
          state_next = need_init ? INIT_ISSUE : NEXT_ISSUE;
        end
      end
      INIT_ISSUE: begin
        if (core_ready) begin
          core_init  = 1'b1;
          state_next = INIT_WAIT;
        end
      end
      INIT_WAIT: begin
        if (seen_busy && core_ready) state_next = NEXT_ISSUE;
      end
      NEXT_ISSUE: begin
        if (core_ready) begin
          core_next  = 1'b1;
          state_next = NEXT_WAIT;
        end
      end
      NEXT_WAIT: begin
        if (seen_busy && core_ready && core_result_valid) state_next = RESP;
      end
      RESP: begin
        if (rsp_ready[last_grant]) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant  <= 1'b1;
      key_loaded  <= 1'b0;
      key_owner   <= 1'b0;
      seen_busy   <= 1'b0;
      rsp_data    <= '0;
      core_key    <= '0;
      core_block  <= '0;
      core_encdec <= 1'b0;
      core_keylen <= 1'b0;
      init_cnt    <= '0;
      op_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|grant) begin
            core_key    <= g_key;
            core_block  <= g_block;
            core_encdec <= g_encdec;
            core_keylen <= g_keylen;
            last_grant  <= grant_idx;
          end
        end
        INIT_ISSUE: begin
          if (core_ready) begin
            key_loaded <= 1'b0;
            seen_busy  <= 1'b0;
            if (init_cnt != '1) init_cnt <= init_cnt + CNT_W'(1);
          end
        end
        INIT_WAIT: begin
          if (!core_ready) begin
            seen_busy <= 1'b1;
          end else if (seen_busy) begin
            key_loaded <= 1'b1;
            key_owner  <= last_grant;
          end
        end
        NEXT_ISSUE: begin
          if (core_ready) seen_busy <= 1'b0;
        end
        NEXT_WAIT: begin
          if (!core_ready) seen_busy <= 1'b1;
          else if (seen_busy && core_result_valid) rsp_data <= core_result;
        end
        RESP: begin
          if (rsp_ready[last_grant] && (op_cnt != '1)) op_cnt <= op_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Directed bench for aes_core_arbiter with a behavioural aes_core stand-in.
module tb_aes_core_arbiter;

  localparam int unsigned CNT_W = 3;

  localparam logic [255:0] K128  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KA    = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KB    = {128'h8899aabbccddeeff0011223344556677, 128'h0};
  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [1:0]       req_valid, req_ready, req_encdec, req_keylen, req_rekey;
  logic [511:0]     req_key;
  logic [255:0]     req_block;
  logic [1:0]       rsp_valid, rsp_ready;
  logic [127:0]     rsp_data;
  logic             core_encdec, core_init, core_next, core_keylen;
  logic [255:0]     core_key;
  logic [127:0]     core_block;
  logic             core_ready, core_result_valid;
  logic [127:0]     core_result;
  logic             busy;
  logic [CNT_W-1:0] init_cnt, op_cnt;

  int vectors = 0;
  int miscompares = 0;
  int init_pulses = 0;
  int next_pulses = 0;
  int proto_err = 0;

  always #5 clk = ~clk;

  aes_core_arbiter #(.NUM_REQ(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_encdec(req_encdec),
    .req_keylen(req_keylen), .req_rekey(req_rekey), .req_key(req_key),
    .req_block(req_block), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .core_encdec(core_encdec), .core_init(core_init),
    .core_next(core_next), .core_key(core_key), .core_keylen(core_keylen),
    .core_block(core_block), .core_ready(core_ready), .core_result(core_result),
    .core_result_valid(core_result_valid), .busy(busy),
    .init_cnt(init_cnt), .op_cnt(op_cnt)
  );

  // Known FIPS-197 answers; any other context gets a key-dependent scramble.
  function automatic logic [127:0] model_result(input logic [255:0] k, input logic kl,
                                                input logic [127:0] b, input logic ed);
    if (!kl && k == K128 && ed && b == PT)     return CT128;
    if (!kl && k == K128 && !ed && b == CT128) return PT;
    if (kl && k == K256 && ed && b == PT)      return CT256;
    return b ^ k[255:128] ^ k[127:0] ^ {127'b0, kl} ^ {128{ed}} ^ 128'h5a5a_a5a5_3c3c_c3c3_0f0f_f0f0_1234_5678;
  endfunction

  // Behavioural core: result uses the key captured at the last init.
  logic [255:0] ex_key;
  logic         ex_keylen, ex_valid, m_is_next;
  logic [127:0] m_pending;
  int           m_cnt;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_ready <= 1'b1; core_result_valid <= 1'b0; core_result <= '0;
      ex_key <= '0; ex_keylen <= 1'b0; ex_valid <= 1'b0; m_is_next <= 1'b0;
      m_pending <= '0; m_cnt <= 0;
    end else if (core_init) begin
      ex_key <= core_key; ex_keylen <= core_keylen; ex_valid <= 1'b1;
      core_ready <= 1'b0; core_result_valid <= 1'b0; m_is_next <= 1'b0; m_cnt <= 3;
    end else if (core_next) begin
      m_pending <= ex_valid ? model_result(ex_key, ex_keylen, core_block, core_encdec)
                            : 128'hbad0_bad0_bad0_bad0_bad0_bad0_bad0_bad0;
      core_ready <= 1'b0; core_result_valid <= 1'b0; m_is_next <= 1'b1; m_cnt <= 4;
    end else if (!core_ready) begin
      if (m_cnt == 1) begin
        core_ready <= 1'b1;
        core_result_valid <= m_is_next;
        if (m_is_next) core_result <= m_pending;
      end
      m_cnt <= m_cnt - 1;
    end
  end

  always @(posedge clk) begin
    if (reset_n) begin
      if (core_init) init_pulses++;
      if (core_next) next_pulses++;
      if (core_init && core_next) proto_err++;
      if ((core_init || core_next) && !core_ready) proto_err++;
    end
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input logic idx, input logic ed, input logic kl, input logic rk,
                         input logic [255:0] k, input logic [127:0] b);
    req_encdec[idx] = ed; req_keylen[idx] = kl; req_rekey[idx] = rk;
    if (idx) begin req_key[511:256] = k; req_block[255:128] = b; end
    else     begin req_key[255:0]   = k; req_block[127:0]   = b; end
  endtask

  task automatic wait_grant(input logic [1:0] want);
    int n = 0;
    #1;
    while (req_ready !== want && n < 60) begin @(negedge clk); #1; n++; end
  endtask

  task automatic wait_rsp(input logic [1:0] want);
    int n = 0;
    while (rsp_valid !== want && n < 100) begin @(negedge clk); #1; n++; end
  endtask

  // Full single transaction from requester idx, with inputs scrambled after grant.
  task automatic do_req(input string tag, input logic idx, input logic ed, input logic kl,
                        input logic rk, input logic [255:0] k, input logic [127:0] b,
                        input logic exp_init, input logic [127:0] exp_data,
                        input int exp_ic, input int exp_oc);
    logic [1:0] oh;
    int ip0;
    oh = idx ? 2'b10 : 2'b01;
    ip0 = init_pulses;
    set_req(idx, ed, kl, rk, k, b);
    req_valid[idx] = 1'b1;
    wait_grant(oh);
    check({tag, " req_ready"}, 256'(req_ready), 256'(oh));
    @(negedge clk);
    req_valid[idx] = 1'b0;
    set_req(idx, ~ed, ~kl, 1'b0, ~k, ~b);
    #1;
    check({tag, " busy"}, 256'(busy), 256'(1));
    wait_rsp(oh);
    check({tag, " rsp_valid"}, 256'(rsp_valid), 256'(oh));
    check({tag, " rsp_data"}, 256'(rsp_data), 256'(exp_data));
    check({tag, " core_key"}, core_key, k);
    check({tag, " core_ctl"}, 256'({core_keylen, core_encdec, core_block}), 256'({kl, ed, b}));
    check({tag, " init_pulses"}, 256'(init_pulses - ip0), 256'(exp_init));
    rsp_ready[idx] = 1'b1;
    @(negedge clk);
    rsp_ready = '0;
    #1;
    check({tag, " rsp_cleared"}, 256'({rsp_valid, busy}), 256'(0));
    check({tag, " counters"}, 256'({init_cnt, op_cnt}), 256'({CNT_W'(exp_ic), CNT_W'(exp_oc)}));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " ctl"}, 256'({req_ready, rsp_valid, core_init, core_next, busy, core_encdec, core_keylen}), 256'(0));
    check({tag, " rsp_data"}, 256'(rsp_data), 256'(0));
    check({tag, " core_key"}, core_key, 256'(0));
    check({tag, " core_block"}, 256'(core_block), 256'(0));
    check({tag, " counters"}, 256'({init_cnt, op_cnt}), 256'(0));
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic         idx, encdec, keylen, rekey;
    logic [255:0] key;
    logic [127:0] block;
    logic         exp_init;
    logic [127:0] exp_data;
    int           exp_ic, exp_oc;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]   oh;
    logic [127:0] exp_d;
    int           ip0;

    // op_cnt saturates at 7 on the last entry (CNT_W=3)
    tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, K128, PT,    1'b1, CT128, 1, 1};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b0, K128, CT128, 1'b0, PT,    1, 2};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, K128, PT,    1'b1, CT128, 2, 3};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, K256, PT,    1'b1, CT256, 3, 4};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, KA, 128'h0f0e0d0c0b0a09080706050403020100, 1'b1,
               model_result(KA, 1'b0, 128'h0f0e0d0c0b0a09080706050403020100, 1'b1), 4, 5};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b0, KA, 128'hdeadbeef_cafef00d_01234567_89abcdef, 1'b0,
               model_result(KA, 1'b0, 128'hdeadbeef_cafef00d_01234567_89abcdef, 1'b0), 4, 6};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b0, K256, PT,    1'b1, CT256, 5, 7};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, K128, CT128, 1'b1, PT,    6, 7};

    reset_n = 1'b0;
    req_valid = '0; req_encdec = '0; req_keylen = '0; req_rekey = '0;
    req_key = '0; req_block = '0; rsp_ready = '0;
    @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++)
      do_req($sformatf("vec%0d", i), tbl[i].idx, tbl[i].encdec, tbl[i].keylen, tbl[i].rekey,
             tbl[i].key, tbl[i].block, tbl[i].exp_init, tbl[i].exp_data,
             tbl[i].exp_ic, tbl[i].exp_oc);

    // Response back-pressure while the other requester is waiting
    @(negedge clk);
    set_req(1'b1, 1'b1, 1'b0, 1'b0, KB, PT);
    req_valid[1] = 1'b1;
    wait_grant(2'b10);
    check("stall grant", 256'(req_ready), 256'(2'b10));
    @(negedge clk);
    req_valid[1] = 1'b0;
    exp_d = model_result(KB, 1'b0, PT, 1'b1);
    wait_rsp(2'b10);
    set_req(1'b0, 1'b1, 1'b0, 1'b0, K128, PT);
    req_valid[0] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      check("stall rsp_valid", 256'(rsp_valid), 256'(2'b10));
      check("stall rsp_data", 256'(rsp_data), 256'(exp_d));
      check("stall no_grant", 256'({req_ready, busy}), 256'(3'b001));
    end
    req_valid[0] = 1'b0;
    rsp_ready[1] = 1'b1;
    @(negedge clk);
    rsp_ready = '0;
    #1;
    check("stall released", 256'({rsp_valid, busy, req_ready}), 256'(0));

    // Both requesters continuously valid with distinct keys
    pulse_reset();
    ip0 = init_pulses;
    set_req(1'b0, 1'b1, 1'b0, 1'b0, KA, PT);
    set_req(1'b1, 1'b1, 1'b0, 1'b0, KB, PT);
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    for (int g = 0; g < 4; g++) begin
      oh = (g % 2 == 1) ? 2'b10 : 2'b01;
      wait_grant(oh);
      check($sformatf("alt grant%0d", g), 256'(req_ready), 256'(oh));
      @(negedge clk);
      if (g == 3) req_valid = '0;
      #1;
      wait_rsp(oh);
      check($sformatf("alt rsp%0d", g), 256'({rsp_valid, rsp_data}),
            256'({oh, model_result((g % 2 == 1) ? KB : KA, 1'b0, PT, 1'b1)}));
      @(negedge clk);
    end
    rsp_ready = '0;
    #1;
    check("alt counters", 256'({init_cnt, op_cnt}), 256'({CNT_W'(4), CNT_W'(4)}));
    check("alt init_pulses", 256'(init_pulses - ip0), 256'(4));

    // Reset while the core is computing
    do_req("pre_rst", 1'b0, 1'b1, 1'b0, 1'b0, K128, PT, 1'b1, CT128, 5, 5);
    ip0 = next_pulses;
    set_req(1'b0, 1'b1, 1'b0, 1'b0, K128, PT);
    req_valid[0] = 1'b1;
    for (int n = 0; n < 60 && next_pulses == ip0; n++) @(negedge clk);
    req_valid[0] = 1'b0;
    check("midrst next_issued", 256'(next_pulses - ip0), 256'(1));
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    do_req("post_rst", 1'b0, 1'b1, 1'b0, 1'b0, K128, PT, 1'b1, CT128, 1, 1);

    check("core protocol", 256'(proto_err), 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/aes_core_arbiter.md
Name: aes_core_arbiter

Overview:
Shares a single aes_core instance between two requesters, such as a CBC engine and a CTR engine. It accepts block requests over valid/ready, grants them round-robin, and tracks which requester's key is currently expanded in the core. It issues a core init only when the key context must change, then issues next and returns the result over a valid/ready response channel. It sits between the requester engines and aes_core and owns every control input of the core.

Parameters:
NUM_REQ, 2, number of requesters; only 2 is supported, and an elaboration error is raised otherwise.
CNT_W, 16, width of the saturating statistics counters.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
req_valid  in  2  per-requester request valid
req_ready  out  2  per-requester accept; a 1-cycle pulse at grant
req_encdec  in  2  1 = encipher, 0 = decipher
req_keylen  in  2  0 = AES-128, 1 = AES-256
req_rekey  in  2  force key re-expansion for this request
req_key  in  512  [255:0] belongs to requester 0, [511:256] to requester 1
req_block  in  256  [127:0] belongs to requester 0, [255:128] to requester 1
rsp_valid  out  2  result valid for the owning requester
rsp_ready  in  2  per-requester response accept
rsp_data  out  128  result data, shared by both requesters
core_encdec  out  1  to aes_core encdec
core_init  out  1  to aes_core init; 1-cycle pulse
core_next  out  1  to aes_core next; 1-cycle pulse
core_key  out  256  to aes_core key
core_keylen  out  1  to aes_core keylen
core_block  out  128  to aes_core block
core_ready  in  1  from aes_core ready
core_result  in  128  from aes_core result
core_result_valid  in  1  from aes_core result_valid
busy  out  1  high whenever the FSM is not in IDLE
init_cnt  out  CNT_W  number of core init pulses issued; saturating
op_cnt  out  CNT_W  number of completed responses; saturating

Behaviour:
- Reset values (asynchronous, reset_n low): state IDLE; req_ready, rsp_valid, core_init, core_next and busy are 0; rsp_data, core_key, core_block, core_encdec and core_keylen are 0; key_loaded=0; key_owner=0; last_grant=1, so requester 0 wins first; both counters are 0.
- States: IDLE, INIT_ISSUE, INIT_WAIT, NEXT_ISSUE, NEXT_WAIT, RESP.
- IDLE:
  - If any req_valid is set, grant round-robin. When both are valid, grant the requester that is not last_grant.
  - On grant: pulse req_ready[g]; latch key, keylen, block and encdec of the granted requester into the core_* registers; set last_grant=g.
  - need_init = !key_loaded | key_owner!=g | req_rekey[g] | keylen differs from the latched keylen.
  - If need_init, go to INIT_ISSUE; otherwise go to NEXT_ISSUE.
- INIT_ISSUE: when core_ready=1, pulse core_init for 1 cycle, clear key_loaded, clear the seen_busy flag, increment init_cnt, and go to INIT_WAIT.
- INIT_WAIT:
  - Set seen_busy when core_ready=0.
  - When seen_busy=1 and core_ready=1: set key_loaded=1 and key_owner=g, then go to NEXT_ISSUE.
- NEXT_ISSUE: when core_ready=1, pulse core_next for 1 cycle, clear seen_busy, and go to NEXT_WAIT.
- NEXT_WAIT:
  - Set seen_busy when core_ready=0.
  - When seen_busy=1, core_ready=1 and core_result_valid=1: capture core_result into rsp_data, set rsp_valid[g]=1, and go to RESP.
- RESP: hold rsp_valid[g] and rsp_data stable until rsp_ready[g]=1. On that cycle, clear rsp_valid, increment op_cnt, and return to IDLE.
- Single outstanding operation: at most one request is in flight. The minimum gap between a response handshake and the next grant is 1 cycle (the IDLE cycle).
- Latched core_* inputs remain stable from grant until the response is accepted. Requesters may change their req_* inputs after req_ready.
- core_init and core_next are never high together, and neither is ever asserted while core_ready=0.
- A req_valid that drops before grant is simply never granted. A request that has been granted cannot be cancelled.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Reset mid-operation: everything returns to reset values and key_loaded=0. aes_core shares the same reset_n, so no cleanup handshake is needed.

Decomposition:
- Package aes_arb_pkg: FSM state localparams, NUM_REQ, and the requester index slicing constants (KEY_W=256, BLK_W=128).
- Sub-module aes_rr_arbiter: the 2-way round-robin grant logic.
  - Inputs: req (2 bits), last_grant, enable.
  - Outputs: grant (one-hot) and grant_idx.
  - Combinational; last_grant is stored in the parent.

Test Plan:
- Requester 0, encipher, AES-128:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, block 00112233445566778899aabbccddeeff.
  - Response: exactly one core_init, then one core_next; rsp_data = 69c4e0d86a7b0430d8cdb78070b4c55a; init_cnt=1, op_cnt=1.
- Same requester again, no rekey, decipher of that ciphertext:
  - Response: no core_init pulse; rsp_data = 00112233445566778899aabbccddeeff; init_cnt stays 1.
- Both req_valid held high, each with a distinct AES-128 key:
  - Response: grants alternate 0,1,0,1; a core_init precedes every grant because the owner changes; init_cnt=4 after 4 operations.
- rsp_ready held low for 20 cycles:
  - Response: rsp_valid and rsp_data stay stable; no new req_ready; busy=1 throughout.
- req_rekey=1 with an unchanged key, and separately a keylen change from 0 to 1 with the 256-bit FIPS-197 key 000102…1f:
  - Response: core_init is reissued in both cases; the AES-256 result is 8ea2b7ca516745bfeafc49904b496089.
- reset_n asserted during NEXT_WAIT:
  - Response: all outputs return to reset values immediately; the next request triggers a core_init even for the same requester.
